uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The master drives a byte plus its valid flag; the slave answers with ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out LSB first with one start and one stop bit, CYCLE clocks per bit.
//
// state       | meaning
// S_IDLE      | line high, ready for a byte
// S_START     | start bit (low) on the line
// S_SEND_BYTE | data bits 0..7, LSB first
// S_STOP      | stop bit (high)
module uart_tx #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   tx_bus,
    output logic       tx_pin
);

    localparam int          CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CYC_LAST = 16'(CYCLE - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_SEND_BYTE = 2'd2,
        S_STOP      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_cycle_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_tx_pin;
    logic        w_bit_end;
    logic        w_handshake;
    logic        w_cnt_clr;
    logic        w_pin_next;

    assign w_bit_end   = (r_cycle_cnt == CYC_LAST);
    assign w_handshake = (r_state == S_IDLE) && tx_bus.tx_data_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pin_next   = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_pin_next = 1'b1;
                if (tx_bus.tx_data_valid) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_pin_next = 1'b0;
                if (w_bit_end) begin
                    w_next_state = S_SEND_BYTE;
                end
            end
            S_SEND_BYTE: begin
                w_pin_next = r_shift[0];
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                w_pin_next = 1'b1;
                if (w_bit_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_pin_next   = 1'b1;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bit time restarts on any state change and at each data bit boundary.
    assign w_cnt_clr = (w_next_state != r_state) ||
                       ((r_state == S_SEND_BYTE) && w_bit_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 16'd0;
        end else if (w_cnt_clr) begin
            r_cycle_cnt <= 16'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    // Wraps 7 -> 0 on the same edge that leaves S_SEND_BYTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
        end else if (r_state != S_SEND_BYTE) begin
            r_bit_cnt <= 3'd0;
        end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 8'h00;
        end else if (w_handshake) begin
            r_shift <= tx_bus.tx_data;
        end else if ((r_state == S_SEND_BYTE) && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // Line level is registered one clock behind the state so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_pin <= 1'b1;
        end else begin
            r_tx_pin <= w_pin_next;
        end
    end

    assign tx_pin               = r_tx_pin;
    assign tx_bus.tx_data_ready = (r_state == S_IDLE);

endmodule
